// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
//
// Shared types and constants for the fetch-stage branch target buffer.
//   word_t       : 32-bit machine word / program counter
//   WORD_BYTES   : bytes per instruction; sequential fetch advances by this
//   upd_kind_e   : what a resolved-branch update does to the table
//   seq_pc()     : fall-through PC (pc + WORD_BYTES, wraps mod 2^32)
//
// The BTB entry struct is declared inside branch_predictor itself because
// its tag and counter widths follow the module parameters.
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

    typedef logic [31:0] word_t;

    localparam int WORD_BYTES = 4;

    // UPD_HIT   : entry already tracks this PC, train its counter/target
    // UPD_ALLOC : taken miss, overwrite whatever lives at this index
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_HIT   = 2'd1,
        UPD_ALLOC = 2'd2
    } upd_kind_e;

    function automatic word_t seq_pc(input word_t pc);
        return pc + word_t'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// branch_predictor_sat_counter
//
// Combinational next value of a W-bit up/down counter that saturates at
// both 0 and 2^W-1.
//   cur     in  W  current counter value
//   inc     in  1  count up (stops at all-ones)
//   dec     in  1  count down (stops at zero)
//   set_max in  1  force all-ones; wins over inc/dec
//   next    out W  resulting value
// With none of the controls set the value passes through unchanged.
// -----------------------------------------------------------------------------
module branch_predictor_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    input  logic         set_max,
    output logic [W-1:0] next
);

    always_comb begin
        next = cur;
        if (set_max) begin
            next = '1;
        end else if (inc && (cur != '1)) begin
            next = cur + 1'b1;
        end else if (dec && (cur != '0)) begin
            next = cur - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with a saturating direction counter per
// entry. Fetch looks up every cycle (combinational, no bypass of same-cycle
// updates); the MEM stage commits at most one resolved branch/jump per cycle.
//
// Parameters
//   ENTRIES : number of entries, power of two, >= 2
//   CTR_W   : direction counter width, >= 1 (1 = last-outcome prediction)
//
// Ports
//   CLK         in  1   clock, state changes on the rising edge
//   nRST        in  1   asynchronous active-low reset
//   lu_pc       in  32  fetch PC to look up
//   lu_hit      out 1   valid entry with matching tag
//   lu_taken    out 1   hit and counter MSB set
//   lu_next_pc  out 32  predicted next fetch PC
//   upd_en      in  1   commit one resolved control-flow instruction
//   upd_pc      in  32  PC of the resolved instruction
//   upd_taken   in  1   actual outcome
//   upd_uncond  in  1   J/JAL, always taken
//   upd_target  in  32  actual target when taken
//   clear       in  1   synchronous invalidate-all, beats upd_en
// -----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t lu_pc,
    output logic  lu_hit,
    output logic  lu_taken,
    output word_t lu_next_pc,
    input  logic  upd_en,
    input  word_t upd_pc,
    input  logic  upd_taken,
    input  logic  upd_uncond,
    input  word_t upd_target,
    input  logic  clear
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Reset leaves counters weakly not-taken; fresh conditional allocations
    // start weakly taken (for CTR_W=1 these are 0 and 1).
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            target;
        logic [CTR_W-1:0] ctr;
    } btb_entry_t;

    localparam btb_entry_t RESET_ENTRY = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    CTR_WEAK_NT
    };

    // Flattened view of all entries for the read muxes.
    btb_entry_t entry_arr [ENTRIES];

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] lu_idx;
    logic [TAG_W-1:0] lu_tag;
    btb_entry_t       lu_entry;

    assign lu_idx   = lu_pc[IDX_W+1:2];
    assign lu_tag   = lu_pc[31:IDX_W+2];
    assign lu_entry = entry_arr[lu_idx];

    assign lu_hit     = lu_entry.valid && (lu_entry.tag == lu_tag);
    assign lu_taken   = lu_hit && lu_entry.ctr[CTR_W-1];
    assign lu_next_pc = lu_taken ? lu_entry.target : seq_pc(lu_pc);

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    btb_entry_t       upd_entry;
    logic             upd_hit;
    upd_kind_e        upd_kind;
    logic [CTR_W-1:0] ctr_next;
    btb_entry_t       wr_entry;

    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[31:IDX_W+2];
    assign upd_entry = entry_arr[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    // Not-taken misses are deliberately not allocated: they would only
    // evict a useful entry to record a prediction that equals PC+4 anyway.
    always_comb begin
        upd_kind = UPD_NONE;
        if (upd_en) begin
            if (upd_hit) begin
                upd_kind = UPD_HIT;
            end else if (upd_taken || upd_uncond) begin
                upd_kind = UPD_ALLOC;
            end
        end
    end

    branch_predictor_sat_counter #(
        .W(CTR_W)
    ) u_ctr (
        .cur     (upd_entry.ctr),
        .inc     (upd_taken),
        .dec     (!upd_taken && !upd_uncond),
        .set_max (upd_uncond),
        .next    (ctr_next)
    );

    always_comb begin
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = upd_tag;
        // A not-taken outcome carries no meaningful target; keep the old one.
        wr_entry.target = (upd_taken || upd_uncond) ? upd_target : upd_entry.target;
        if (upd_kind == UPD_HIT) begin
            wr_entry.ctr = ctr_next;
        end else if (upd_uncond) begin
            wr_entry.ctr = '1;
        end else begin
            wr_entry.ctr = CTR_WEAK_T;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: one register per entry, written only when selected.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : gen_entry
            btb_entry_t entry_reg;
            logic       wr_sel;

            assign wr_sel = (upd_kind != UPD_NONE) && (upd_idx == IDX_W'(gi));

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    entry_reg <= RESET_ENTRY;
                end else if (clear) begin
                    entry_reg.valid <= 1'b0;
                end else if (wr_sel) begin
                    entry_reg <= wr_entry;
                end
            end

            assign entry_arr[gi] = entry_reg;
        end
    endgenerate

    // Byte-offset bits of both PCs do not take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lu_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Drives branch_predictor (ENTRIES=16, CTR_W=2) through directed scenarios
// and a randomized phase, comparing every lookup against a table model that
// works directly from the PC arithmetic (index = (pc/4) mod 16, tag = pc/64)
// and integer saturating counters.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int N      = 16;
    localparam int CMAX   = 3;   // 2^CTR_W - 1
    localparam int CTHR   = 2;   // taken when counter >= 2^(CTR_W-1)

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] lu_pc;
    logic        lu_hit;
    logic        lu_taken;
    logic [31:0] lu_next_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_uncond;
    logic [31:0] upd_target;
    logic        clear;

    always #5 CLK = ~CLK;

    branch_predictor #(
        .ENTRIES(16),
        .CTR_W  (2)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .lu_pc      (lu_pc),
        .lu_hit     (lu_hit),
        .lu_taken   (lu_taken),
        .lu_next_pc (lu_next_pc),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_uncond (upd_uncond),
        .upd_target (upd_target),
        .clear      (clear)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference table
    bit          m_valid  [N];
    int unsigned m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc / 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
    endtask

    task automatic model_update(input logic en, input logic [31:0] pc, input logic tk,
                                input logic un, input logic [31:0] tgt, input logic clr);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (clr) begin
            for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
        end else if (en) begin
            if (hit) begin
                if (un) begin
                    m_ctr[i] = CMAX;
                    m_target[i] = tgt;
                end else if (tk) begin
                    m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
                    m_target[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (tk || un) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(pc);
                m_target[i] = tgt;
                m_ctr[i]    = un ? CMAX : CTHR;
            end
        end
    endtask

    // One transaction: drive lookup + optional update, check the lookup
    // against the pre-update model, then advance the model past the edge.
    task automatic step(input string name, input logic [31:0] lpc, input logic en,
                        input logic [31:0] upc, input logic tk, input logic un,
                        input logic [31:0] tgt, input logic clr);
        int   i;
        logic e_hit, e_taken;
        logic [31:0] e_next;
        @(negedge CLK);
        lu_pc      = lpc;
        upd_en     = en;
        upd_pc     = upc;
        upd_taken  = tk;
        upd_uncond = un;
        upd_target = tgt;
        clear      = clr;
        #1;
        i       = idx_of(lpc);
        e_hit   = m_valid[i] && (m_tag[i] == tag_of(lpc));
        e_taken = e_hit && (m_ctr[i] >= CTHR);
        e_next  = e_taken ? m_target[i] : lpc + 32'd4;
        $display("%-12s lu=%08h hit=%0b tk=%0b nxt=%08h | upd=%0b pc=%08h t=%0b u=%0b tgt=%08h clr=%0b",
                 name, lpc, lu_hit, lu_taken, lu_next_pc, en, upc, tk, un, tgt, clr);
        check($sformatf("%s.hit", name),   32'(lu_hit),   32'(e_hit));
        check($sformatf("%s.taken", name), 32'(lu_taken), 32'(e_taken));
        check($sformatf("%s.next", name),  lu_next_pc,    e_next);
        @(posedge CLK);
        model_update(en, upc, tk, un, tgt, clr);
    endtask

    task automatic look(input string name, input logic [31:0] lpc);
        step(name, lpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Assert reset with junk update/clear traffic, check the reset response,
    // then release away from the active edge.
    task automatic do_reset(input string name);
        @(negedge CLK);
        nRST       = 1'b0;
        lu_pc      = 32'h40;
        upd_en     = 1'b1;
        upd_pc     = 32'h40;
        upd_taken  = 1'b1;
        upd_uncond = 1'b1;
        upd_target = 32'hdead_0000;
        clear      = 1'b0;
        #1;
        $display("%-12s reset asserted lu=%08h hit=%0b tk=%0b nxt=%08h", name, lu_pc, lu_hit, lu_taken, lu_next_pc);
        check($sformatf("%s.hit", name),   32'(lu_hit),   32'h0);
        check($sformatf("%s.taken", name), 32'(lu_taken), 32'h0);
        check($sformatf("%s.next", name),  lu_next_pc,    32'h44);
        model_reset();
        repeat (2) @(negedge CLK);
        nRST   = 1'b1;
        upd_en = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        lu_pc = '0; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_uncond = 1'b0; upd_target = '0; clear = 1'b0;
        model_reset();

        do_reset("reset0");
        look("post_rst", 32'h40);

        // First taken allocation, then prediction
        step("alloc40", 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0);
        look("look40", 32'h40);

        // Counter walks down and saturates, then back up
        for (int k = 0; k < 3; k++) begin
            step($sformatf("nt40_%0d", k), 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
            look($sformatf("nt40_%0d_l", k), 32'h40);
        end
        for (int k = 0; k < 3; k++) begin
            step($sformatf("tk40_%0d", k), 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 1'b0);
            look($sformatf("tk40_%0d_l", k), 32'h40);
        end

        // Alias at index 0
        look("alias80", 32'h80);
        step("alloc80", 32'h80, 1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 1'b0);
        look("look80", 32'h80);
        look("evict40", 32'h40);

        // Mid-run reset wipes everything
        do_reset("reset1");
        look("post_rst1", 32'h40);
        look("post_rst1b", 32'h80);

        // Same-cycle lookup/update: no bypass
        step("same40", 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h300, 1'b0);
        look("same40_n", 32'h40);

        // Unconditional jump, one not-taken, then clear beats update
        step("jal10", 32'h10, 1'b1, 32'h10, 1'b1, 1'b1, 32'h500, 1'b0);
        step("nt10", 32'h10, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0);
        look("look10", 32'h10);
        step("clr_upd", 32'h10, 1'b1, 32'h20, 1'b1, 1'b0, 32'h600, 1'b1);
        look("clr10", 32'h10);
        look("clr20", 32'h20);
        look("clr40", 32'h40);

        // Randomized traffic over a small PC pool to force hits and aliases
        begin
            logic [31:0] last_upc;
            last_upc = 32'h0;
            for (int n = 0; n < 400; n++) begin
                logic [31:0] lpc, upc;
                logic        en, tk, un, clr;
                upc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2)
                      | 32'($urandom_range(0, 3));
                lpc = ($urandom_range(0, 1) == 1) ? last_upc
                      : (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
                en  = ($urandom_range(0, 3) != 0);
                un  = ($urandom_range(0, 7) == 0);
                tk  = un | ($urandom_range(0, 2) != 0);
                clr = ($urandom_range(0, 49) == 0);
                step($sformatf("rnd%0d", n), lpc, en, upc, tk, un, $urandom, clr);
                last_upc = upc;
            end
        end

        do_reset("reset2");
        look("final40", 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
